// File: rtl/motion_object_line_buffer.sv
// motion_object_line_buffer: double-banked motion-object line buffer with erase-after-read.
// One bank is written from the object shifter while the other is displayed and erased behind the beam.
module motion_object_line_buffer #(
    parameter int         WIDTH  = 256,
    parameter logic [2:0] TRANSP = 3'b111
) (
    input  logic       clk,
    input  logic       RESETn,
    input  logic       ce5,
    input  logic [2:0] AR,
    input  logic       WREN,
    input  logic       LOADX,
    input  logic [7:0] XPOS,
    input  logic       PLAYER2,
    input  logic       NEWLINE,
    output logic [2:0] MPX,
    output logic       MVALID,
    output logic       READY
);
    localparam int AW = $clog2(WIDTH);
    localparam logic [AW:0] SWEEP_END = (AW + 1)'(WIDTH);

    typedef enum logic {CLR, RUN} state_t;

    state_t state, state_nx;
    logic [AW:0] sweep;
    logic bank;
    logic [AW-1:0] wp, rx, waddr;
    logic [2:0] mem0 [WIDTH];
    logic [2:0] mem1 [WIDTH];
    logic [2:0] rd;
    logic tick, pix_we, rd_we, sweep_we;
    logic we0, we1;
    logic [AW-1:0] wa0, wa1;
    logic [2:0] wd0, wd1;

    function automatic logic [AW-1:0] step(input logic [AW-1:0] a, input logic dn);
        return dn ? ((a == '0) ? AW'(WIDTH - 1) : a - 1'b1)
                  : ((a == AW'(WIDTH - 1)) ? '0 : a + 1'b1);
    endfunction

    always_comb begin
        state_nx = (state == CLR && sweep == SWEEP_END) ? RUN : state;
        READY    = state == RUN;
    end

    assign tick     = state == RUN && ce5;
    assign waddr    = LOADX ? AW'(XPOS) : wp;
    assign rd       = bank ? mem0[rx] : mem1[rx];
    assign pix_we   = tick && WREN && AR != TRANSP;
    assign rd_we    = tick && !NEWLINE;
    assign sweep_we = state == CLR && sweep < SWEEP_END;

    // Each bank sees at most one write per clk: sweep, object pixel, or erase behind the read.
    always_comb begin
        we0 = sweep_we || (bank ? rd_we : pix_we);
        wa0 = sweep_we ? sweep[AW-1:0] : (bank ? rx : waddr);
        wd0 = (sweep_we || bank) ? TRANSP : AR;
        we1 = sweep_we || (bank ? pix_we : rd_we);
        wa1 = sweep_we ? sweep[AW-1:0] : (bank ? waddr : rx);
        wd1 = (sweep_we || !bank) ? TRANSP : AR;
    end

    always_ff @(posedge clk) begin
        if (we0) mem0[wa0] <= wd0;
        if (we1) mem1[wa1] <= wd1;
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state  <= CLR;
            sweep  <= '0;
            bank   <= 1'b0;
            wp     <= '0;
            rx     <= '0;
            MPX    <= TRANSP;
            MVALID <= 1'b0;
        end else begin
            state <= state_nx;
            if (sweep_we) sweep <= sweep + 1'b1;
            if (tick) begin
                if (WREN) wp <= step(waddr, PLAYER2);
                else if (LOADX) wp <= waddr;
                if (NEWLINE) begin
                    bank   <= ~bank;
                    rx     <= '0;
                    MPX    <= TRANSP;
                    MVALID <= 1'b0;
                end else begin
                    MPX    <= rd;
                    MVALID <= rd != TRANSP;
                    rx     <= step(rx, 1'b0);
                end
            end
        end
    end
endmodule

// File: tb/tb_motion_object_line_buffer.sv
// tb_motion_object_line_buffer: directed line scenarios plus randomized traffic
// checked against a line-level reference model of the two banks.
module tb_motion_object_line_buffer;
    logic clk = 0, RESETn = 1, ce5 = 0, WREN = 0, LOADX = 0, PLAYER2 = 0, NEWLINE = 0;
    logic [2:0] AR = 0;
    logic [7:0] XPOS = 0;
    logic [2:0] MPX;
    logic MVALID, READY;

    int total = 0, bad = 0;
    int m_mem[2][256];
    int m_bank, m_wp, m_rx, m_px, m_v;
    logic [2:0] obs_px[256];
    logic obs_v[256];
    int exp_px[256];

    always #5 clk = ~clk;

    motion_object_line_buffer dut (
        .clk(clk), .RESETn(RESETn), .ce5(ce5), .AR(AR), .WREN(WREN), .LOADX(LOADX),
        .XPOS(XPOS), .PLAYER2(PLAYER2), .NEWLINE(NEWLINE),
        .MPX(MPX), .MVALID(MVALID), .READY(READY)
    );

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 256; i++) m_mem[b][i] = 7;
        m_bank = 0; m_wp = 0; m_rx = 0; m_px = 7; m_v = 0;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 256; i++) exp_px[i] = 7;
    endtask

    // One pixel-rate step in RUN: drive, clock, then advance the line model.
    task automatic tick(input logic c, input logic [2:0] ar, input logic wr, input logic ld,
                        input int xp, input logic p2, input logic nl);
        int a;
        @(negedge clk);
        ce5 = c; AR = ar; WREN = wr; LOADX = ld; XPOS = 8'(xp); PLAYER2 = p2; NEWLINE = nl;
        @(posedge clk);
        if (c) begin
            a = ld ? xp : m_wp;
            if (wr) begin
                if (ar != 7) m_mem[m_bank][a] = ar;
                m_wp = (a + (p2 ? 255 : 1)) % 256;
            end else if (ld) m_wp = xp;
            if (nl) begin
                m_bank ^= 1; m_rx = 0; m_px = 7; m_v = 0;
            end else begin
                m_px = m_mem[1 - m_bank][m_rx];
                m_v = m_px != 7;
                m_mem[1 - m_bank][m_rx] = 7;
                m_rx = (m_rx + 1) % 256;
            end
        end
        #1;
    endtask

    task automatic read_line();
        for (int i = 0; i < 256; i++) begin
            tick(1, 0, 0, 0, 0, 0, 0);
            obs_px[i] = MPX;
            obs_v[i] = MVALID;
        end
    endtask

    task automatic flush();
        tick(1, 0, 0, 0, 0, 0, 1); read_line();
        tick(1, 0, 0, 0, 0, 0, 1); read_line();
    endtask

    task automatic test_reset();
        int n;
        #1 RESETn = 0;
        ce5 = 1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (MPX !== 3'd7) begin bad++; $display("FAIL rst_mpx got=%0d want=7", MPX); end
        total++; if (MVALID !== 1'b0) begin bad++; $display("FAIL rst_mvalid got=%0b want=0", MVALID); end
        total++; if (READY !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b want=0", READY); end
        @(negedge clk); RESETn = 1; n = 0;
        while (n < 1000) begin @(posedge clk); n++; #1; if (READY === 1'b1) break; end
        total++; if (n !== 257) begin bad++; $display("FAIL ready_latency got=%0d want=257", n); end
        model_reset();
        clear_exp();
        read_line();
        for (int i = 0; i < 256; i++) begin
            total++;
            if (obs_px[i] !== 3'(exp_px[i]) || obs_v[i] !== 1'b0) begin
                bad++; $display("FAIL blank1 x=%0d got=%0d/%0b want=7/0", i, obs_px[i], obs_v[i]);
            end
        end
        tick(1, 0, 0, 0, 0, 0, 1);
        read_line();
        for (int i = 0; i < 256; i++) begin
            total++;
            if (obs_px[i] !== 3'(exp_px[i]) || obs_v[i] !== 1'b0) begin
                bad++; $display("FAIL blank2 x=%0d got=%0d/%0b want=7/0", i, obs_px[i], obs_v[i]);
            end
        end
    endtask

    task automatic write_obj(input logic p2);
        tick(1, 0, 0, 1, 10, p2, 0);
        tick(1, 3, 1, 0, 0, p2, 0);
        tick(1, 7, 1, 0, 0, p2, 0);
        tick(1, 5, 1, 0, 0, p2, 0);
        tick(1, 0, 0, 0, 0, p2, 1);
        read_line();
    endtask

    task automatic test_forward();
        flush();
        write_obj(0);
        clear_exp(); exp_px[10] = 3; exp_px[12] = 5;
        for (int i = 0; i < 256; i++) begin
            total++;
            if (obs_px[i] !== 3'(exp_px[i]) || obs_v[i] !== (exp_px[i] != 7)) begin
                bad++; $display("FAIL fwd x=%0d got=%0d/%0b want=%0d", i, obs_px[i], obs_v[i], exp_px[i]);
            end
        end
        tick(1, 0, 0, 0, 0, 0, 1); read_line();
        tick(1, 0, 0, 0, 0, 0, 1); read_line();
        clear_exp();
        for (int i = 0; i < 256; i++) begin
            total++;
            if (obs_px[i] !== 3'(exp_px[i]) || obs_v[i] !== 1'b0) begin
                bad++; $display("FAIL fwd_erased x=%0d got=%0d/%0b want=7/0", i, obs_px[i], obs_v[i]);
            end
        end
    endtask

    task automatic test_reverse();
        flush();
        write_obj(1);
        clear_exp(); exp_px[10] = 3; exp_px[8] = 5;
        for (int i = 0; i < 256; i++) begin
            total++;
            if (obs_px[i] !== 3'(exp_px[i]) || obs_v[i] !== (exp_px[i] != 7)) begin
                bad++; $display("FAIL rev x=%0d got=%0d/%0b want=%0d", i, obs_px[i], obs_v[i], exp_px[i]);
            end
        end
    endtask

    task automatic test_wrap();
        flush();
        tick(1, 1, 1, 1, 254, 0, 0);
        tick(1, 2, 1, 0, 0, 0, 0);
        tick(1, 3, 1, 0, 0, 0, 0);
        tick(1, 4, 1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0, 1);
        read_line();
        clear_exp(); exp_px[254] = 1; exp_px[255] = 2; exp_px[0] = 3; exp_px[1] = 4;
        for (int i = 0; i < 256; i++) begin
            total++;
            if (obs_px[i] !== 3'(exp_px[i]) || obs_v[i] !== (exp_px[i] != 7)) begin
                bad++; $display("FAIL wrap x=%0d got=%0d/%0b want=%0d", i, obs_px[i], obs_v[i], exp_px[i]);
            end
        end
    endtask

    task automatic test_newline_write();
        flush();
        tick(1, 0, 0, 1, 50, 0, 0);
        tick(1, 6, 1, 0, 0, 0, 1);
        read_line();
        clear_exp(); exp_px[50] = 6;
        for (int i = 0; i < 256; i++) begin
            total++;
            if (obs_px[i] !== 3'(exp_px[i]) || obs_v[i] !== (exp_px[i] != 7)) begin
                bad++; $display("FAIL nl_write x=%0d got=%0d/%0b want=%0d", i, obs_px[i], obs_v[i], exp_px[i]);
            end
        end
        tick(1, 0, 0, 0, 0, 0, 1);
        read_line();
        total++;
        if (obs_px[50] !== 3'd7 || obs_v[50] !== 1'b0) begin
            bad++; $display("FAIL nl_write_next x=50 got=%0d/%0b want=7/0", obs_px[50], obs_v[50]);
        end
    endtask

    task automatic test_random();
        logic c, wr, ld, p2, nl;
        logic [2:0] ar;
        int xp;
        for (int k = 0; k < 3000; k++) begin
            c = $urandom_range(0, 9) != 0;
            wr = $urandom_range(0, 2) != 0;
            ld = $urandom_range(0, 15) == 0;
            p2 = $urandom_range(0, 1) == 1;
            nl = $urandom_range(0, 63) == 0;
            ar = 3'($urandom_range(0, 7));
            xp = $urandom_range(0, 255);
            tick(c, ar, wr, ld, xp, p2, nl);
            total++;
            if (MPX !== 3'(m_px) || MVALID !== 1'(m_v) || READY !== 1'b1) begin
                bad++;
                $display("FAIL rand k=%0d got=%0d/%0b/%0b want=%0d/%0d/1", k, MPX, MVALID, READY, m_px, m_v);
            end
        end
    endtask

    task automatic test_reset_midline();
        int n;
        flush();
        tick(1, 0, 0, 1, 99, 0, 0);
        tick(1, 1, 1, 0, 0, 0, 0);
        tick(1, 2, 1, 0, 0, 0, 0);
        tick(1, 3, 1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i <= 100; i++) tick(1, 0, 0, 0, 0, 0, 0);
        total++;
        if (MPX !== 3'd2 || MVALID !== 1'b1) begin
            bad++; $display("FAIL mid_pre x=100 got=%0d/%0b want=2/1", MPX, MVALID);
        end
        #2 RESETn = 0;
        #1;
        total++;
        if (MPX !== 3'd7 || MVALID !== 1'b0 || READY !== 1'b0) begin
            bad++; $display("FAIL mid_async got=%0d/%0b/%0b want=7/0/0", MPX, MVALID, READY);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); RESETn = 1; n = 0;
        while (n < 1000) begin @(posedge clk); n++; #1; if (READY === 1'b1) break; end
        total++; if (n !== 257) begin bad++; $display("FAIL mid_ready_latency got=%0d want=257", n); end
        model_reset();
        for (int p = 0; p < 2; p++) begin
            if (p == 1) tick(1, 0, 0, 0, 0, 0, 1);
            read_line();
            for (int i = 0; i < 256; i++) begin
                total++;
                if (obs_px[i] !== 3'd7 || obs_v[i] !== 1'b0) begin
                    bad++; $display("FAIL mid_swept p=%0d x=%0d got=%0d/%0b want=7/0", p, i, obs_px[i], obs_v[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_wrap();
        test_newline_write();
        test_random();
        test_reset_midline();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
